eth_frame_pattern_ctrl: RTL and testbench
=========================================

# eth_frame_pattern_ctrl

Sequences run-time updates of the frame-pattern memory read by the Ethernet frame matcher. Accepts one pattern slot update (slot 0..2) as a host byte stream, writes it into the shared 30-bit pattern memory, and fills the unused tail with don't-care words. The slot's `match_en` bit is held low for the whole update, so the matcher never evaluates a half-written pattern. Sits in the control clock domain between the register interface and the matcher's `match_en` input and memory write port.

## Interface

- `DRAIN_CYCLES`, default 8: cycles `match_en[slot]` stays low before the first memory write. This covers the matcher's CDC of `match_en` plus one in-flight frame byte. Legal range 1..255.
- `clk`  in  1  control clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_en`  in  3  host-requested per-slot match enable.
- `match_en`  out  3  enable to the matcher (registered).
- `upd_req`  in  1  start an update; level, sampled only in IDLE.
- `upd_slot`  in  2  target slot; 3 is illegal.
- `upd_len`  in  11  pattern length in words, 1..2047; 0 is illegal.
- `upd_busy`  out  1  high from the first non-IDLE state until ACK inclusive.
- `upd_ack`  out  1  one-cycle pulse when the update has completed or been rejected.
- `upd_err`  out  1  valid with `upd_ack`; 1 = rejected.
- `pat_valid`, `pat_ready`  in/out  1  pattern beat handshake.
- `pat_data`  in  8  expected byte.
- `pat_dc`  in  1  byte is don't-care.
- `pat_end`  in  1  frame must end at or before this byte.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  11  write address.
- `mem_wdata`  out  30  word image; the slot lane is filled, other bits are 0.
- `mem_wstrb`  out  3  per-slot lane enable. Lane k covers bits [8k+7:8k], 24+2k (dc) and 25+2k (end).

## Operation

- States: IDLE, CHECK, DRAIN, WRITE, FILL, ACK.
- IDLE:
  - If `upd_req` = 1, latch `upd_slot` and `upd_len` and go to CHECK.
  - `upd_req` is ignored in every other state.
- CHECK:
  - If slot = 3 or len = 0: set `upd_err` = 1 and go to ACK. No memory writes; `match_en` is not forced.
  - Otherwise: force `match_en[slot]` = 0, load the drain counter with DRAIN_CYCLES-1, and go to DRAIN.
- DRAIN: decrement the counter each cycle. At 0, go to WRITE with the address counter at 0.
- WRITE:
  - `pat_ready` = 1 only in this state.
  - Each accepted beat at address a produces, on the next cycle: `mem_we` = 1, `mem_addr` = a, `mem_wstrb` = one-hot(slot), and lane = {`pat_end`, `pat_dc`, `pat_data`}.
  - The beat with a = len-1 moves the block to FILL.
  - Stalls (`pat_valid` = 0) are unlimited.
- FILL:
  - Writes addresses len..2047, one per cycle, with lane = {end 0, dc 1, data 0x00}.
  - After the 2047 write, go to ACK.
  - When len = 2047 only address 2047 is filled.
- ACK: one-cycle `upd_ack`, then IDLE. The forced-zero on the slot is released in this cycle.
- `match_en` rule: next `match_en[i]` = `cfg_en[i]` & ~(forced & slot == i). Other slots follow `cfg_en` throughout an update.
- Reset mid-update:
  - Returns to IDLE immediately; the partially written pattern stays in memory.
  - `match_en` resets to 0. Software must rewrite the slot before re-enabling it.

## Timing

- Reset values: `match_en` 0, `upd_busy` 0, `upd_ack` 0, `upd_err` 0, `pat_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `mem_wstrb` 0.
- `cfg_en` to `match_en`: 1 cycle.
- `upd_req` high in IDLE (cycle T):
  - CHECK at T+1.
  - `match_en[slot]` = 0 from T+2.
  - DRAIN occupies T+2..T+1+DRAIN_CYCLES.
  - WRITE from T+2+DRAIN_CYCLES.
- Memory write lags its handshake by exactly 1 cycle.
- Total duration with zero stalls: 3 + DRAIN_CYCLES + 2048 cycles from T to `upd_ack`.
- Rejected request: `upd_ack` with `upd_err` = 1 at T+2.
- `upd_err` is cleared on the cycle after ACK.
- `upd_req` still high in the IDLE cycle after ACK starts a new update. Host must drop `upd_req` on `upd_ack`.

## Test plan

- Reset asserted mid-FILL → all outputs at reset values within the same cycle; IDLE after release; `match_en` = 0 until `cfg_en` is seen again.
- `cfg_en` = 3'b111; update slot 1, len 4, bytes 0x11..0x44, last beat `pat_end` = 1:
  - `match_en` = 3'b101 from T+2 until ACK.
  - Addresses 0..3 written with `mem_wstrb` = 3'b010 and wdata[15:8] = 0x11..0x44; address 3 has bit 27 set.
  - Addresses 4..2047 have bit 26 set.
  - `upd_ack` with `upd_err` = 0; `match_en` = 3'b111 one cycle after ACK.
- Update with `upd_slot` = 3, and separately with `upd_len` = 0 → `upd_ack` and `upd_err` at T+2, no `mem_we`, `match_en` unchanged.
- Random `pat_valid` gaps during WRITE → addresses contiguous, no duplicate or missing writes, exactly len beats consumed, `pat_ready` low outside WRITE.
- During a slot 0 update, toggle `cfg_en[2]` and pulse `upd_req` again → `match_en[2]` tracks with 1-cycle latency; second request ignored until IDLE.
- DRAIN_CYCLES = 1, len = 2047 → WRITE begins at T+3, a single FILL write to address 2047, `upd_ack` at T+2052.

Source files
------------

// File: rtl/eth_frame_pattern_ctrl.sv
// Writes one pattern slot (0..2) of the shared 2048 x 30-bit frame-pattern memory from a
// host byte stream, pads the tail with don't-care words, and holds that slot's match enable low meanwhile.
`timescale 1ns/1ps
module eth_frame_pattern_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cfg_en,
  output logic [2:0]  match_en,
  input  logic        upd_req,
  input  logic [1:0]  upd_slot,
  input  logic [10:0] upd_len,
  output logic        upd_busy,
  output logic        upd_ack,
  output logic        upd_err,
  input  logic        pat_valid,
  output logic        pat_ready,
  input  logic [7:0]  pat_data,
  input  logic        pat_dc,
  input  logic        pat_end,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [29:0] mem_wdata,
  output logic [2:0]  mem_wstrb
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    FILL  = 3'd4,
    ACK   = 3'd5
  } state_t;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 32'd1);

  function automatic logic [2:0] slot_onehot(input logic [1:0] slot);
    logic [2:0] oh;
    case (slot)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Lane k holds data in [8k+7:8k], dc at bit 24+2k and end at bit 25+2k.
  function automatic logic [29:0] lane_word(input logic [1:0] slot, input logic pend,
                                            input logic pdc, input logic [7:0] pdata);
    logic [29:0] w;
    w = 30'd0;
    case (slot)
      2'd0: begin w[7:0]   = pdata; w[24] = pdc; w[25] = pend; end
      2'd1: begin w[15:8]  = pdata; w[26] = pdc; w[27] = pend; end
      2'd2: begin w[23:16] = pdata; w[28] = pdc; w[29] = pend; end
      default: w = 30'd0;
    endcase
    return w;
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  slot_r, slot_s;
  logic [10:0] len_r, len_s;
  logic [7:0]  drain_r, drain_s;
  logic [11:0] addr_r, addr_s;
  logic        force_s, err_s, we_s;
  logic [10:0] waddr_s;
  logic [29:0] wdata_s;
  logic [2:0]  wstrb_s;

  logic [2:0]  match_en_r;
  logic        busy_r, ack_r, err_r, ready_r, we_r;
  logic [10:0] waddr_r;
  logic [29:0] wdata_r;
  logic [2:0]  wstrb_r;

  // Next-state, counter and write-issue decode.
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    len_s   = len_r;
    drain_s = drain_r;
    addr_s  = addr_r;
    force_s = 1'b0;
    err_s   = 1'b0;
    we_s    = 1'b0;
    waddr_s = 11'd0;
    wdata_s = 30'd0;
    wstrb_s = 3'b000;
    case (state_r)
      IDLE: begin
        if (upd_req) begin
          state_s = CHECK;
          slot_s  = upd_slot;
          len_s   = upd_len;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if ((slot_r == 2'd3) || (len_r == 11'd0)) begin
          state_s = ACK;
          err_s   = 1'b1;
        end else begin
          force_s = 1'b1;
          drain_s = DRAIN_LOAD;
          state_s = DRAIN;
        end
      end
      DRAIN: begin
        force_s = 1'b1;
        if (drain_r == 8'd0) begin
          state_s = WRITE;
          addr_s  = 12'd0;
        end else begin
          drain_s = drain_r - 8'd1;
        end
      end
      WRITE: begin
        force_s = 1'b1;
        if (pat_valid) begin
          we_s    = 1'b1;
          waddr_s = addr_r[10:0];
          wdata_s = lane_word(slot_r, pat_end, pat_dc, pat_data);
          wstrb_s = slot_onehot(slot_r);
          addr_s  = addr_r + 12'd1;
          if (addr_r[10:0] == (len_r - 11'd1)) begin
            state_s = FILL;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      FILL: begin
        force_s = 1'b1;
        // addr_r wraps into bit 11 once word 2047 has been issued; ACK waits one more cycle.
        if (!addr_r[11]) begin
          we_s    = 1'b1;
          waddr_s = addr_r[10:0];
          wdata_s = lane_word(slot_r, 1'b0, 1'b1, 8'h00);
          wstrb_s = slot_onehot(slot_r);
          addr_s  = addr_r + 12'd1;
        end else begin
          state_s = ACK;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and sequencing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      slot_r  <= 2'd0;
      len_r   <= 11'd0;
      drain_r <= 8'd0;
      addr_r  <= 12'd0;
    end else begin
      state_r <= state_s;
      slot_r  <= slot_s;
      len_r   <= len_s;
      drain_r <= drain_s;
      addr_r  <= addr_s;
    end
  end

  // Registered outputs; the write port lags its handshake by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_en_r <= 3'b000;
      busy_r     <= 1'b0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      ready_r    <= 1'b0;
      we_r       <= 1'b0;
      waddr_r    <= 11'd0;
      wdata_r    <= 30'd0;
      wstrb_r    <= 3'b000;
    end else begin
      match_en_r <= cfg_en & ~(force_s ? slot_onehot(slot_r) : 3'b000);
      busy_r     <= (state_s != IDLE);
      ack_r      <= (state_s == ACK);
      err_r      <= err_s;
      ready_r    <= (state_s == WRITE);
      we_r       <= we_s;
      waddr_r    <= waddr_s;
      wdata_r    <= wdata_s;
      wstrb_r    <= wstrb_s;
    end
  end

  assign match_en  = match_en_r;
  assign upd_busy  = busy_r;
  assign upd_ack   = ack_r;
  assign upd_err   = err_r;
  assign pat_ready = ready_r;
  assign mem_we    = we_r;
  assign mem_addr  = waddr_r;
  assign mem_wdata = wdata_r;
  assign mem_wstrb = wstrb_r;

endmodule

// File: tb/tb_eth_frame_pattern_ctrl.sv
// Randomized bench for eth_frame_pattern_ctrl: a timeline model predicts every output each
// cycle; directed cases pin the model with hand-computed values.
`timescale 1ns/1ps
module tb_eth_frame_pattern_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cfg_en;
  logic [2:0]  match_en;
  logic        upd_req;
  logic [1:0]  upd_slot;
  logic [10:0] upd_len;
  logic        upd_busy, upd_ack, upd_err;
  logic        pat_valid, pat_ready;
  logic [7:0]  pat_data;
  logic        pat_dc, pat_end;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [29:0] mem_wdata;
  logic [2:0]  mem_wstrb;

  // second instance with DRAIN_CYCLES = 1 for the long-pattern boundary case
  logic [2:0]  cfg_en2 = 3'b000;
  logic [2:0]  match_en2;
  logic        req2;
  logic        busy2, ack2, err2, ready2, we2;
  logic [10:0] addr2;
  logic [29:0] wdata2;
  logic [2:0]  wstrb2;

  eth_frame_pattern_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .match_en(match_en),
    .upd_req(upd_req), .upd_slot(upd_slot), .upd_len(upd_len),
    .upd_busy(upd_busy), .upd_ack(upd_ack), .upd_err(upd_err),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
    .pat_dc(pat_dc), .pat_end(pat_end),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  eth_frame_pattern_ctrl #(.DRAIN_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en2), .match_en(match_en2),
    .upd_req(req2), .upd_slot(2'd0), .upd_len(11'd2047),
    .upd_busy(busy2), .upd_ack(ack2), .upd_err(err2),
    .pat_valid(1'b1), .pat_ready(ready2), .pat_data(8'h5A),
    .pat_dc(1'b0), .pat_end(1'b0),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .mem_wstrb(wstrb2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // timeline model of the update in progress
  bit          m_act = 1'b0, m_rej, m_ackk;
  int          m_t, m_beats, m_fs, m_ack, m_slot, m_len;
  bit          pend_v = 1'b0;
  int          pend_addr;
  logic [29:0] pend_word;
  int          dut_beats;
  logic [2:0]  cfg_last = 3'b000;
  logic        rst_last = 1'b0;
  logic [29:0] img [0:2047];
  int          snap_cyc = -1;
  logic [2:0]  snap_me;

  always @(negedge clk) begin : cmp
    int ph, a_e;
    logic [2:0] mask, s_e;
    logic [29:0] w_e;
    bit we_e, ack_e;
    if (!rst_n) begin
      chk("rst_match_en", 64'(match_en), 64'd0);
      chk("rst_busy", 64'(upd_busy), 64'd0);
      chk("rst_ack", 64'(upd_ack), 64'd0);
      chk("rst_err", 64'(upd_err), 64'd0);
      chk("rst_ready", 64'(pat_ready), 64'd0);
      chk("rst_mem", 64'({mem_we, mem_addr, mem_wdata, mem_wstrb}), 64'd0);
      m_act  = 1'b0;
      pend_v = 1'b0;
    end else begin
      ph = 0;
      if (m_act) begin
        if (cyc == m_t + 1)          ph = 1;
        else if (m_rej)              ph = 5;
        else if (cyc <= m_t + 1 + D) ph = 2;
        else if (m_beats < m_len)    ph = 3;
        else                         ph = 4;
      end
      mask = (m_act && !m_rej && cyc >= m_t + 2) ? 3'(1 << m_slot) : 3'b000;
      chk("match_en", 64'(match_en), 64'(rst_last ? (cfg_last & ~mask) : 3'b000));
      chk("pat_ready", 64'(pat_ready), 64'(ph == 3));
      chk("upd_busy", 64'(upd_busy), 64'(m_act && cyc >= m_t + 1));
      ack_e = m_act && m_ackk && (cyc == m_ack);
      chk("upd_ack", 64'(upd_ack), 64'(ack_e));
      chk("upd_err", 64'(upd_err), 64'(ack_e && m_rej));

      we_e = 1'b0; a_e = 0; w_e = 30'd0; s_e = 3'b000;
      if (pend_v) begin
        we_e = 1'b1; a_e = pend_addr; w_e = pend_word; s_e = 3'(1 << m_slot);
        pend_v = 1'b0;
      end else if (m_act && !m_rej && m_beats == m_len &&
                   cyc > m_fs && cyc <= m_fs + 2048 - m_len) begin
        we_e = 1'b1; a_e = m_len + cyc - m_fs - 1;
        w_e = 30'd1 << (24 + 2 * m_slot); s_e = 3'(1 << m_slot);
      end
      chk("mem_we", 64'(mem_we), 64'(we_e));
      if (we_e) begin
        chk("mem_addr", 64'(mem_addr), 64'(a_e));
        chk("mem_wdata", 64'(mem_wdata), 64'(w_e));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(s_e));
      end
      if (mem_we) img[mem_addr] = mem_wdata;
      if (pat_valid && pat_ready) dut_beats++;
      if (cyc == snap_cyc) snap_me = match_en;

      if (ph == 3 && pat_valid) begin
        pend_v    = 1'b1;
        pend_addr = m_beats;
        pend_word = (30'(pat_end) << (25 + 2 * m_slot)) | (30'(pat_dc) << (24 + 2 * m_slot)) |
                    (30'(pat_data) << (8 * m_slot));
        m_beats++;
        if (m_beats == m_len) begin
          m_fs   = cyc + 1;
          m_ack  = m_fs + 2049 - m_len;
          m_ackk = 1'b1;
        end
      end
      if (ack_e) begin
        if (!m_rej) chk("beats_consumed", 64'(dut_beats), 64'(m_len));
        m_act = 1'b0;
      end else if (!m_act && upd_req) begin
        m_act     = 1'b1;
        m_t       = cyc;
        m_slot    = int'(upd_slot);
        m_len     = int'(upd_len);
        m_rej     = (upd_slot == 2'd3) || (upd_len == 11'd0);
        m_beats   = 0;
        m_ackk    = m_rej;
        m_ack     = cyc + 2;
        dut_beats = 0;
      end
    end
    cfg_last = cfg_en;
    rst_last = rst_n;
  end

  // Drives one update from IDLE until upd_ack; returns the ack cycle (-1 on timeout).
  task automatic run_update(input logic [1:0] s, input logic [10:0] l, input int vpct,
                            input bit dir, output int t_ack);
    int k, budget;
    bit acc;
    k = 0; budget = 0; t_ack = -1;
    upd_req = 1'b1; upd_slot = s; upd_len = l;
    while (t_ack < 0 && budget < 8000) begin
      if (dir) begin
        pat_valid = 1'b1;
        pat_data  = 8'(17 * (k + 1));
        pat_dc    = 1'b0;
        pat_end   = (k == int'(l) - 1);
      end else begin
        pat_valid = ($urandom_range(0, 99) < vpct);
        pat_data  = 8'($urandom);
        pat_dc    = 1'($urandom);
        pat_end   = 1'($urandom);
        if ($urandom_range(0, 3) == 0) cfg_en = 3'($urandom);
      end
      @(negedge clk);
      acc = pat_valid && pat_ready;
      if (upd_ack) t_ack = cyc;
      @(posedge clk); #1;
      if (acc) k++;
      budget++;
      upd_req = !dir && (t_ack < 0) && ($urandom_range(0, 9) == 0);
      if (!dir) begin
        upd_slot = 2'($urandom);
        upd_len  = 11'($urandom);
      end
    end
    upd_req = 1'b0; pat_valid = 1'b0;
    chk("update_finished", 64'(t_ack >= 0), 64'd1);
  endtask

  initial begin
    int t0, ta, first_rdy, nw2, n2047, t_ack2;
    logic [29:0] w2047;
    logic [2:0] s_strb2;
    rst_n = 1'b0; cfg_en = 3'b000; upd_req = 1'b0; upd_slot = 2'd0; upd_len = 11'd0;
    pat_valid = 1'b0; pat_data = 8'h00; pat_dc = 1'b0; pat_end = 1'b0; req2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_match_en", 64'(match_en), 64'd0);
    chk("post_reset_busy", 64'(upd_busy), 64'd0);
    @(posedge clk); #1 cfg_en = 3'b111;
    @(posedge clk); #1;

    // slot 1, len 4, bytes 0x11..0x44, end flag on the last beat
    t0 = cyc; snap_cyc = t0 + 100;
    run_update(2'd1, 11'd4, 100, 1'b1, ta);
    chk("dir_ack_time", 64'(ta), 64'(t0 + 3 + D + 2048));
    chk("dir_match_mid", 64'(snap_me), 64'(3'b101));
    @(negedge clk);
    chk("dir_match_after", 64'(match_en), 64'(3'b111));
    chk("dir_img0", 64'(img[0]), 64'(30'h0000_1100));
    chk("dir_img3", 64'(img[3]), 64'(30'h0800_4400));
    chk("dir_img4", 64'(img[4]), 64'(30'h0400_0000));
    chk("dir_img2047", 64'(img[2047]), 64'(30'h0400_0000));
    @(posedge clk); #1;

    // illegal slot and zero length are rejected at T+2
    t0 = cyc;
    run_update(2'd3, 11'd5, 100, 1'b1, ta);
    chk("rej_slot_ack", 64'(ta), 64'(t0 + 2));
    t0 = cyc;
    run_update(2'd0, 11'd0, 100, 1'b1, ta);
    chk("rej_len_ack", 64'(ta), 64'(t0 + 2));

    // reset in the middle of FILL
    upd_req = 1'b1; upd_slot = 2'd2; upd_len = 11'd3; pat_valid = 1'b1;
    @(posedge clk); #1 upd_req = 1'b0;
    repeat (D + 12) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midfill_rst_we", 64'(mem_we), 64'd0);
    chk("midfill_rst_match", 64'(match_en), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; cfg_en = 3'b011; pat_valid = 1'b0;
    @(negedge clk);
    chk("release_match_zero", 64'(match_en), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_match_cfg", 64'(match_en), 64'(3'b011));
    chk("release_idle", 64'(upd_busy), 64'd0);
    @(posedge clk); #1;

    // randomized updates with stalls, cfg_en toggling and ignored requests
    for (int i = 0; i < 8; i++) begin
      run_update((i == 0) ? 2'd0 : 2'($urandom_range(0, 2)),
                 (i == 3) ? 11'd2047 : 11'($urandom_range(1, 60)),
                 40 + $urandom_range(0, 50), 1'b0, ta);
    end

    // DRAIN_CYCLES = 1, len 2047, no stalls
    t0 = cyc; req2 = 1'b1;
    first_rdy = -1; nw2 = 0; n2047 = 0; t_ack2 = -1; w2047 = 30'd0; s_strb2 = 3'b001;
    for (int j = 0; j < 3000 && t_ack2 < 0; j++) begin
      @(negedge clk);
      if (ready2 && first_rdy < 0) first_rdy = cyc;
      if (we2) begin
        nw2++;
        if (wstrb2 != 3'b001) s_strb2 = wstrb2;
        if (addr2 == 11'd2047) begin n2047++; w2047 = wdata2; end
      end
      if (ack2) begin
        t_ack2 = cyc;
        chk("d1_err", 64'(err2), 64'd0);
        chk("d1_busy_at_ack", 64'(busy2), 64'd1);
      end
      @(posedge clk); #1 req2 = 1'b0;
    end
    chk("d1_write_start", 64'(first_rdy), 64'(t0 + 3));
    chk("d1_ack_time", 64'(t_ack2), 64'(t0 + 2052));
    chk("d1_write_count", 64'(nw2), 64'd2048);
    chk("d1_fill_2047_once", 64'(n2047), 64'd1);
    chk("d1_fill_word", 64'(w2047), 64'(30'h0100_0000));
    chk("d1_strb", 64'(s_strb2), 64'(3'b001));
    chk("d1_match_en", 64'(match_en2), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
